alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Accumulator sequencer that drives an external adder: ADD/SUB go through ISSUE/CAPTURE,
// LDA/CLR complete straight into DONE. One command in flight at a time.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_operand,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic             add_oe,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_cout,
  output logic [WIDTH-1:0] acc_out,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             done
);

  // state   | meaning
  // IDLE    | ready for a command
  // ISSUE   | adder driven, result settling
  // CAPTURE | adder driven, result latched at end of cycle
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDA = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             busy;
  logic             a_msb, b_msb, r_msb, v_calc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      operand_q <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      z_q       <= z_d;
      v_q       <= v_d;
    end
  end

  // Overflow is judged from the accumulator and operand as presented to the adder.
  always_comb begin
    a_msb  = acc_q[WIDTH-1];
    b_msb  = operand_q[WIDTH-1];
    r_msb  = add_result[WIDTH-1];
    v_calc = 1'b0;
    if (op_q == OP_SUB) begin
      v_calc = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      v_calc = (a_msb == b_msb) && (r_msb != a_msb);
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    c_d       = c_q;
    z_d       = z_q;
    v_d       = v_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          operand_d = req_operand;
          case (req_op)
            OP_LDA: begin
              acc_d   = req_operand;
              z_d     = (req_operand == '0);
              state_d = DONE;
            end
            OP_CLR: begin
              acc_d   = '0;
              z_d     = 1'b1;
              c_d     = 1'b0;
              v_d     = 1'b0;
              state_d = DONE;
            end
            default: state_d = ISSUE;
          endcase
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        acc_d   = add_result;
        c_d     = add_cout;
        z_d     = (add_result == '0);
        v_d     = v_calc;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == CAPTURE);
    req_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    add_oe    = busy;
    add_sub   = busy && (op_q == OP_SUB);
    add_a     = busy ? acc_q : '0;
    add_b     = busy ? operand_q : '0;
    acc_out   = acc_q;
    flag_c    = c_q;
    flag_z    = z_q;
    flag_v    = v_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: commands push hand-computed results into a scoreboard
// queue, a monitor pops and compares on every done pulse.
module tb_alu_sequencer;

  logic       CLK;
  logic       RST;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_operand;
  logic [7:0] add_a, add_b, add_result;
  logic       add_sub, add_oe, add_cout;
  logic [7:0] acc_out;
  logic       flag_c, flag_z, flag_v, done;
  logic [8:0] sum_w;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] prev_acc;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       v;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  alu_sequencer #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_operand(req_operand),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_oe(add_oe),
    .add_result(add_result), .add_cout(add_cout),
    .acc_out(acc_out), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
    .done(done)
  );

  // external adder: subtract as a + ~b + 1, carry out = no borrow
  assign sum_w = !add_oe ? 9'd0 :
                 add_sub ? ({1'b0, add_a} + {1'b0, ~add_b} + 9'd1) :
                           ({1'b0, add_a} + {1'b0, add_b});
  assign add_result = sum_w[7:0];
  assign add_cout   = sum_w[8];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("acc_out", acc_out, e.acc);
          chk("flag_c", flag_c, e.c);
          chk("flag_z", flag_z, e.z);
          chk("flag_v", flag_v, e.v);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) chk(name, 32'd0, 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] opnd,
                         input logic [7:0] e_acc, input logic e_c, input logic e_z,
                         input logic e_v);
    int lat, oe_n, sub_n, a_bad, b_bad;
    exp_t e;
    lat = op[1] ? 1 : 3;
    wait_ready("ready_timeout");
    req_valid   = 1'b1;
    req_op      = op;
    req_operand = opnd;
    @(posedge CLK);
    #1;
    e.acc = e_acc; e.c = e_c; e.z = e_z; e.v = e_v; e.cyc = cyc + lat - 1;
    sb_q.push_back(e);
    @(negedge CLK);
    req_valid   = 1'b0;
    req_op      = ~op;
    req_operand = ~opnd;
    oe_n = 0; sub_n = 0; a_bad = 0; b_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) break;
      if (add_oe === 1'b1) begin
        oe_n++;
        if (add_a !== prev_acc) a_bad++;
        if (add_b !== opnd) b_bad++;
      end
      if (add_sub === 1'b1) sub_n++;
      @(negedge CLK);
    end
    chk("add_oe_cycles", oe_n, (lat == 3) ? 2 : 0);
    chk("add_sub_cycles", sub_n, (op == 2'b01) ? 2 : 0);
    chk("add_a_bad", a_bad, 0);
    chk("add_b_bad", b_bad, 0);
    wait_ready("ready_return_timeout");
    prev_acc = e_acc;
  endtask

  initial begin
    logic [1:0] sp_op[5];
    logic [7:0] sp_opnd[5];
    logic [7:0] sp_acc[5];
    logic       sp_c[5], sp_z[5], sp_v[5];
    int         acc_cyc[5];
    exp_t       e;

    RST = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_operand = 8'h55;
    prev_acc = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_flags", {flag_c, flag_z, flag_v}, 3'b000);
    chk("rst_done", done, 1'b0);
    chk("rst_add_oe", add_oe, 1'b0);
    RST = 1'b0; req_valid = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", req_ready, 1'b1);
    chk("no_accept_in_rst", acc_out, 8'h00);

    //       op     operand acc    c     z     v
    run_cmd(2'b11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    run_cmd(2'b10, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b00, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b10, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b00, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    run_cmd(2'b10, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    run_cmd(2'b01, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);
    run_cmd(2'b10, 8'h10, 8'h10, 1'b1, 1'b0, 1'b1);
    run_cmd(2'b01, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    run_cmd(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b00, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run_cmd(2'b10, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    run_cmd(2'b11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // req_valid held high across alternating ops
    sp_op   = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
    sp_opnd = '{8'h01, 8'h22, 8'h02, 8'h00, 8'h05};
    sp_acc  = '{8'h01, 8'h22, 8'h20, 8'h00, 8'h05};
    sp_c    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sp_z    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sp_v    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_op      = sp_op[k];
      req_operand = sp_opnd[k];
      wait_ready("stream_ready_timeout");
      @(posedge CLK);
      #1;
      acc_cyc[k] = cyc;
      e.acc = sp_acc[k]; e.c = sp_c[k]; e.z = sp_z[k]; e.v = sp_v[k];
      e.cyc = cyc + (sp_op[k][1] ? 0 : 2);
      sb_q.push_back(e);
      if (k > 0) chk("accept_spacing", acc_cyc[k] - acc_cyc[k-1], sp_op[k-1][1] ? 2 : 4);
      @(negedge CLK);
      chk("ready_busy", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    wait_ready("stream_drain_timeout");

    // reset during CAPTURE of ADD 0x03 with ACC=0x05
    req_valid = 1'b1; req_op = 2'b00; req_operand = 8'h03;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("midrst_issue_oe", add_oe, 1'b1);
    @(negedge CLK);
    chk("midrst_capture_oe", add_oe, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_acc", acc_out, 8'h00);
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_add_oe", add_oe, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_flags", {flag_c, flag_z, flag_v}, 3'b000);
    repeat (4) @(negedge CLK);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
